reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16; entry count, power of two, and equal to 2^TAG_W.
REQ-002 SHALL have parameter TAG_W, default 4; rename-tag width, equal to the register-file rename width.
REQ-003 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- alloc_valid  in  1  issue requests an entry.
- alloc_has_rd  in  1  the instruction writes rd.
- alloc_is_branch  in  1  the instruction is a conditional branch.
- alloc_pred_taken  in  1  predictor decision.
- alloc_rd  in  5  destination register.
- alloc_tag  out  TAG_W  tail index, combinational; valid when rob_full is 0.
- rob_full  out  1  registered; high when count==DEPTH.
- wb_valid  in  1  CDB broadcast.
- wb_tag  in  TAG_W  broadcast tag.
- wb_value  in  32  result value.
- wb_taken  in  1  actual branch outcome.
- wb_target  in  32  correct next PC on mispredict.
- simple_done  in  1  register-file completion pulse for an operand-less instruction.
- simple_tag  in  TAG_W  tag of that instruction.
- commit_valid  out  1  drives register_update_flag.
- commit_rd  out  5  drives register_commit_dest.
- commit_value  out  32  drives register_commit_value.
- commit_tag  out  TAG_W  drives rename_of_commit_ins.
- flush  out  1  one-cycle pulse to the register file, reservation stations and fetch.
- flush_pc  out  32  fetch redirect address.

Function
REQ-005 SHALL keep a circular buffer with head and tail pointers of TAG_W bits and a count of TAG_W+1 bits; pointers wrap DEPTH-1 -> 0.
REQ-006 SHALL store per entry: busy, ready, has_rd, is_branch, pred_taken, rd, value, taken, target.
REQ-007 SHALL, on alloc_valid && !rob_full, write the entry at tail with busy=1 and ready=0, then increment tail.
REQ-008 SHALL ignore alloc_valid while rob_full is high; rob_full is based on the registered count, so a same-cycle commit does not admit the allocation.
REQ-009 SHALL, on wb_valid, set ready and capture value, taken and target for entry wb_tag only when that entry is busy; otherwise the broadcast is dropped.
REQ-010 SHALL, on simple_done, set ready for entry simple_tag; if it coincides with wb_valid to the same tag, the wb fields win.
REQ-011 SHALL commit at most one entry per cycle, and only the head entry when it is busy and ready.
REQ-012 SHALL, at the commit edge, register commit_valid=has_rd, commit_rd, commit_value and commit_tag=head, clear busy, and advance head; commit_valid is high for exactly the following cycle.
REQ-013 SHALL treat a committing branch with taken!=pred_taken as a mispredict: pulse flush=1 with flush_pc=target for one cycle, clear all busy bits, and zero head, tail and count.
REQ-014 SHALL give mispredict flush priority over allocate, writeback and simple_done in the same cycle.
REQ-015 SHALL apply count = count + alloc_accepted - commit on every edge; a simultaneous allocate and commit leaves count unchanged.
REQ-016 SHALL, when rdy is low, hold all state and outputs, including any pulse already asserted.
REQ-017 SHALL set latency from writeback edge N to commit_valid: high during cycle N+2 (ready registered, then commit registered).

Reset
REQ-018 SHALL, on rst, clear all busy and ready bits, zero head, tail and count, and drive commit_valid=0, commit_rd=0, commit_value=0, commit_tag=0, flush=0, flush_pc=0, rob_full=0.
REQ-019 SHALL, when rst is asserted mid-operation, discard all in-flight entries with no commit or flush pulse.

Configuration
REQ-020 SHALL, with ROB_COMMIT_BYPASS_EN defined, commit the head in the same edge as a matching wb_valid (commit_valid high in cycle N+1), using wb_value and wb_taken directly.
REQ-021 SHALL, without ROB_COMMIT_BYPASS_EN, behave exactly as REQ-017.

Structure
REQ-022 SHALL place DEPTH, TAG_W and an entry struct typedef in the shared package cpu_pkg.
REQ-023 SHALL contain a sub-module rob_ptr_ctrl, which owns the head, tail and count update and the full flag.

Verification
REQ-024 SHALL cover: allocate rd=5 as tag 0, wb tag 0 value 0x1234 -> commit_valid, rd=5, value=0x1234, tag=0 in cycle N+2 (N+1 with bypass).
REQ-025 SHALL cover: allocate 16 entries -> rob_full=1; a 17th alloc is ignored; one commit -> rob_full=0 the next cycle and tail wraps to 0.
REQ-026 SHALL cover: wb tags 2 and 1 before tag 0 -> commits occur in order 0, 1, 2 on consecutive cycles.
REQ-027 SHALL cover: branch pred_taken=0, wb taken=1 target 0x100 -> flush=1 with flush_pc=0x100 for one cycle; rob empty; same-cycle alloc dropped.
REQ-028 SHALL cover: rdy=0 for 3 cycles with the head ready -> no commit; commit resumes the cycle after rdy returns.
REQ-029 SHALL cover: rst mid-stream with 5 busy entries -> all outputs 0 next cycle and alloc_tag=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the out-of-order core.
//   DEPTH       : reorder-buffer entry count (must equal 2**TAG_W)
//   TAG_W       : rename-tag width, shared with the register-file rename table
//   rob_entry_t : per-entry state held by the reorder buffer
package cpu_pkg;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        has_rd;
    logic        is_branch;
    logic        pred_taken;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl -- head/tail/count bookkeeping for the reorder buffer.
//   clk, rst       : clock, synchronous active-high reset
//   rdy            : global enable, all state holds while low
//   alloc_req      : issue wants an entry this cycle
//   commit         : head entry retires this cycle
//   flush          : mispredict, zero all pointers (wins over alloc/commit)
//   head, tail     : current pointers (tail doubles as the next alloc tag)
//   full           : registered, high when count == DEPTH
//   alloc_accepted : alloc_req qualified by the registered full flag and flush
module rob_ptr_ctrl #(
  parameter int DEPTH = cpu_pkg::DEPTH,
  parameter int TAG_W = cpu_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_req,
  input  logic             commit,
  input  logic             flush,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic             full,
  output logic             alloc_accepted
);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             full_q, full_d;

  // Full comes from the registered count, so a commit in the same cycle
  // never frees a slot for an allocation.
  assign alloc_accepted = alloc_req && !full_q && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    full_d  = full_q;
    if (rdy) begin
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        // Pointers wrap for free because DEPTH == 2**TAG_W.
        if (alloc_accepted) tail_d = tail_q + TAG_W'(1);
        if (commit)         head_d = head_q + TAG_W'(1);
        count_d = count_q + (TAG_W+1)'(alloc_accepted) - (TAG_W+1)'(commit);
      end
      full_d = (count_d == (TAG_W+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign head = head_q;
  assign tail = tail_q;
  assign full = full_q;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer -- in-order retirement of out-of-order results.
//   clk, rst            : clock, synchronous active-high reset
//   rdy                 : global enable; all state and output pulses hold while low
//   alloc_*             : issue-side allocation request; alloc_tag is the tail index
//   rob_full            : registered, high when every entry is in use
//   wb_*                : CDB broadcast (result value, branch outcome and target)
//   simple_done/_tag    : completion of an instruction with no CDB result
//   commit_*            : registered retirement of the head entry (one-cycle pulse)
//   flush, flush_pc     : one-cycle mispredict pulse and fetch redirect
// Optional macro ROB_COMMIT_BYPASS_EN: a writeback to the head entry commits in
// the same edge, using the broadcast fields directly.
module reorder_buffer #(
  parameter int DEPTH = cpu_pkg::DEPTH,
  parameter int TAG_W = cpu_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic             alloc_has_rd,
  input  logic             alloc_is_branch,
  input  logic             alloc_pred_taken,
  input  logic [4:0]       alloc_rd,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             rob_full,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_taken,
  input  logic [31:0]      wb_target,
  input  logic             simple_done,
  input  logic [TAG_W-1:0] simple_tag,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             flush,
  output logic [31:0]      flush_pc
);
  import cpu_pkg::*;

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic             commit_valid_q, commit_valid_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [31:0]      commit_value_q, commit_value_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  logic [TAG_W-1:0] head, tail;
  logic             full, alloc_accepted;
  rob_entry_t       head_e;
  logic             commit_fire, mispredict;
  logic [31:0]      commit_value_w, commit_target_w;
  logic             commit_taken_w;
`ifdef ROB_COMMIT_BYPASS_EN
  logic             wb_hits_head;
`endif

  rob_ptr_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ptr (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .alloc_req     (alloc_valid),
    .commit        (commit_fire),
    .flush         (mispredict),
    .head          (head),
    .tail          (tail),
    .full          (full),
    .alloc_accepted(alloc_accepted)
  );

  // Retirement decision for the head entry.
  always_comb begin
    head_e = entries_q[head];
`ifdef ROB_COMMIT_BYPASS_EN
    // A broadcast to the head is newer than anything stored there.
    wb_hits_head    = wb_valid && (wb_tag == head);
    commit_fire     = head_e.busy && (head_e.ready || wb_hits_head);
    commit_value_w  = wb_hits_head ? wb_value  : head_e.value;
    commit_taken_w  = wb_hits_head ? wb_taken  : head_e.taken;
    commit_target_w = wb_hits_head ? wb_target : head_e.target;
`else
    commit_fire     = head_e.busy && head_e.ready;
    commit_value_w  = head_e.value;
    commit_taken_w  = head_e.taken;
    commit_target_w = head_e.target;
`endif
    mispredict = commit_fire && head_e.is_branch && (commit_taken_w != head_e.pred_taken);
  end

  always_comb begin
    entries_d      = entries_q;
    commit_valid_d = commit_valid_q;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    flush_d        = flush_q;
    flush_pc_d     = flush_pc_q;
    if (rdy) begin
      commit_valid_d = commit_fire && head_e.has_rd;
      flush_d        = mispredict;
      if (commit_fire) begin
        commit_rd_d    = head_e.rd;
        commit_value_d = commit_value_w;
        commit_tag_d   = head;
      end
      if (mispredict) begin
        flush_pc_d = commit_target_w;
        for (int i = 0; i < DEPTH; i++) begin
          entries_d[i].busy  = 1'b0;
          entries_d[i].ready = 1'b0;
        end
      end else begin
        if (commit_fire) entries_d[head].busy = 1'b0;
        // Ordering matters: writeback overrides simple_done, and a fresh
        // allocation overrides any stale ready left in a free slot.
        if (simple_done) entries_d[simple_tag].ready = 1'b1;
        if (wb_valid && entries_q[wb_tag].busy) begin
          entries_d[wb_tag].ready  = 1'b1;
          entries_d[wb_tag].value  = wb_value;
          entries_d[wb_tag].taken  = wb_taken;
          entries_d[wb_tag].target = wb_target;
        end
        if (alloc_accepted) begin
          entries_d[tail] = '{busy: 1'b1, ready: 1'b0, has_rd: alloc_has_rd,
                              is_branch: alloc_is_branch, pred_taken: alloc_pred_taken,
                              rd: alloc_rd, value: 32'd0, taken: 1'b0, target: 32'd0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      entries_q      <= entries_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  assign alloc_tag    = tail;
  assign rob_full     = full;
  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, rdy;
  logic             alloc_valid, alloc_has_rd, alloc_is_branch, alloc_pred_taken;
  logic [4:0]       alloc_rd;
  logic [TAG_W-1:0] alloc_tag;
  logic             rob_full;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_value;
  logic             wb_taken;
  logic [31:0]      wb_target;
  logic             simple_done;
  logic [TAG_W-1:0] simple_tag;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_value;
  logic [TAG_W-1:0] commit_tag;
  logic             flush;
  logic [31:0]      flush_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd),
    .alloc_is_branch(alloc_is_branch), .alloc_pred_taken(alloc_pred_taken),
    .alloc_rd(alloc_rd), .alloc_tag(alloc_tag), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .simple_done(simple_done), .simple_tag(simple_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .flush(flush), .flush_pc(flush_pc)
  );

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    int         tag;
    bit         has_rd;
    bit [4:0]   rd;
    bit         is_branch;
    bit         pred;
    bit         ready;
    bit         vk;      // result fields came from a writeback
    bit         taken;
    bit [31:0]  value;
    bit [31:0]  target;
  } m_ent_t;

  m_ent_t    mq[$];
  int        m_head = 0;
  bit        e_cv = 0, e_flush = 0, e_vk = 0;
  bit [4:0]  e_rd = 0;
  bit [31:0] e_val = 0, e_pc = 0;
  int        e_tag = 0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int     sz, new_tag;
  bit     do_commit, mis;
  m_ent_t f, n;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_head = 0;
      e_cv = 0; e_flush = 0; e_vk = 0; e_rd = 0; e_val = 0; e_pc = 0; e_tag = 0;
    end else if (rdy) begin
      sz        = mq.size();
      new_tag   = (m_head + sz) % DEPTH;
      do_commit = 0;
      mis       = 0;
      e_cv      = 0;
      e_flush   = 0;
      if (sz > 0) begin
        f = mq[0];
`ifdef ROB_COMMIT_BYPASS_EN
        if (wb_valid && wb_tag == f.tag) begin
          f.ready = 1; f.vk = 1; f.value = wb_value; f.taken = wb_taken; f.target = wb_target;
        end
`endif
        if (f.ready) begin
          do_commit = 1;
          e_cv  = f.has_rd;
          e_rd  = f.rd;
          e_val = f.value;
          e_vk  = f.vk;
          e_tag = f.tag;
          mis   = f.is_branch && (f.taken != f.pred);
        end
      end
      if (mis) begin
        e_flush = 1;
        e_pc    = f.target;
        mq.delete();
        m_head  = 0;
      end else begin
        foreach (mq[k]) begin
          if (simple_done && mq[k].tag == int'(simple_tag)) mq[k].ready = 1;
          if (wb_valid && mq[k].tag == int'(wb_tag)) begin
            mq[k].ready = 1; mq[k].vk = 1;
            mq[k].value = wb_value; mq[k].taken = wb_taken; mq[k].target = wb_target;
          end
        end
        if (do_commit) begin
          void'(mq.pop_front());
          m_head = (m_head + 1) % DEPTH;
        end
        if (alloc_valid && sz < DEPTH) begin
          n = '{tag: new_tag, has_rd: alloc_has_rd, rd: alloc_rd, is_branch: alloc_is_branch,
                pred: alloc_pred_taken, ready: 0, vk: 0, taken: 0, value: 0, target: 0};
          mq.push_back(n);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rob_full", 32'(rob_full), 32'(mq.size() == DEPTH));
      chk("alloc_tag", 32'(alloc_tag), 32'((m_head + mq.size()) % DEPTH));
      chk("commit_valid", 32'(commit_valid), 32'(e_cv));
      chk("flush", 32'(flush), 32'(e_flush));
      if (e_cv) begin
        chk("commit_rd", 32'(commit_rd), 32'(e_rd));
        chk("commit_tag", 32'(commit_tag), 32'(e_tag));
        if (e_vk) chk("commit_value", commit_value, e_val);
      end
      if (e_flush && e_vk) chk("flush_pc", flush_pc, e_pc);
    end
  end

  task automatic idle();
    rst = 0; rdy = 1;
    alloc_valid = 0; alloc_has_rd = 0; alloc_is_branch = 0; alloc_pred_taken = 0; alloc_rd = 0;
    wb_valid = 0; wb_tag = 0; wb_value = 0; wb_taken = 0; wb_target = 0;
    simple_done = 0; simple_tag = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic wb(input int tag, input logic [31:0] val, input bit tk, input logic [31:0] tgt);
    wb_valid = 1; wb_tag = TAG_W'(tag); wb_value = val; wb_taken = tk; wb_target = tgt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int pick;
  int cand[$];

  initial begin
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    chk_en = 1;

    // Single allocate / writeback / commit.
    do_reset();
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    alloc_valid = 1; alloc_has_rd = 1; alloc_rd = 5;
    step();
    alloc_valid = 0;
    chk("alloc_tag_after_one", 32'(alloc_tag), 32'd1);
    wb(0, 32'h1234, 0, 0);
    step();
    wb_valid = 0;
`ifndef ROB_COMMIT_BYPASS_EN
    chk("lat_n1_no_commit", 32'(commit_valid), 32'd0);
    step();
`endif
    chk("lat_commit_valid", 32'(commit_valid), 32'd1);
    chk("lat_commit_rd", 32'(commit_rd), 32'd5);
    chk("lat_commit_value", commit_value, 32'h1234);
    chk("lat_commit_tag", 32'(commit_tag), 32'd0);
    step();
    chk("lat_pulse_end", 32'(commit_valid), 32'd0);

    // Fill to full, reject a 17th, free one slot.
    do_reset();
    alloc_valid = 1; alloc_has_rd = 1;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_rd = 5'(i);
      step();
    end
    chk("full_after_16", 32'(rob_full), 32'd1);
    chk("full_tail_wrapped", 32'(alloc_tag), 32'd0);
    alloc_rd = 5'd31;
    step();
    chk("full_17th_ignored", 32'(rob_full), 32'd1);
    alloc_valid = 0;
    wb(0, 32'hAAAA_0000, 0, 0);
    step();
    wb_valid = 0;
`ifndef ROB_COMMIT_BYPASS_EN
    step();
`endif
    chk("full_cleared", 32'(rob_full), 32'd0);
    chk("full_commit_tag", 32'(commit_tag), 32'd0);
    chk("full_tail_zero", 32'(alloc_tag), 32'd0);

    // Out-of-order writeback, in-order commit.
    do_reset();
    alloc_valid = 1; alloc_has_rd = 1;
    for (int i = 0; i < 3; i++) begin
      alloc_rd = 5'(i + 1);
      step();
    end
    alloc_valid = 0;
    wb(2, 32'h22, 0, 0); step();
    wb(1, 32'h11, 0, 0); step();
    wb(0, 32'h10, 0, 0); step();
    wb_valid = 0;
`ifndef ROB_COMMIT_BYPASS_EN
    step();
`endif
    chk("ooo_tag0", 32'(commit_tag), 32'd0);
    chk("ooo_val0", commit_value, 32'h10);
    step();
    chk("ooo_tag1", 32'(commit_tag), 32'd1);
    chk("ooo_val1", commit_value, 32'h11);
    step();
    chk("ooo_tag2", 32'(commit_tag), 32'd2);
    chk("ooo_val2", commit_value, 32'h22);
    chk("ooo_valid2", 32'(commit_valid), 32'd1);

    // Mispredicted branch flushes and drops a same-cycle allocation.
    do_reset();
    alloc_valid = 1; alloc_has_rd = 0; alloc_is_branch = 1; alloc_pred_taken = 0;
    step();
    alloc_is_branch = 0; alloc_has_rd = 1; alloc_rd = 7;
    step();
    alloc_valid = 0;
    wb(0, 32'h0, 1, 32'h100);
`ifndef ROB_COMMIT_BYPASS_EN
    step();
    wb_valid = 0;
`endif
    alloc_valid = 1; alloc_rd = 9;
    step();
    wb_valid = 0; alloc_valid = 0;
    chk("mis_flush", 32'(flush), 32'd1);
    chk("mis_flush_pc", flush_pc, 32'h100);
    chk("mis_alloc_dropped", 32'(alloc_tag), 32'd0);
    chk("mis_not_full", 32'(rob_full), 32'd0);
    step();
    chk("mis_pulse_end", 32'(flush), 32'd0);

    // rdy low freezes a ready head.
    do_reset();
    alloc_valid = 1; alloc_has_rd = 1; alloc_rd = 3;
    step();
    alloc_valid = 0;
    simple_done = 1; simple_tag = 0;
    step();
    simple_done = 0;
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy_hold_no_commit", 32'(commit_valid), 32'd0);
    end
    rdy = 1;
    step();
    chk("rdy_resume_commit", 32'(commit_valid), 32'd1);
    chk("rdy_resume_rd", 32'(commit_rd), 32'd3);

    // Reset mid-stream.
    do_reset();
    alloc_valid = 1; alloc_has_rd = 1;
    for (int i = 0; i < 5; i++) begin
      alloc_rd = 5'(i + 10);
      step();
    end
    wb(3, 32'hBEEF, 0, 0);
    rst = 1;
    step();
    rst = 0; alloc_valid = 0; wb_valid = 0;
    chk("rst_mid_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_mid_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_mid_commit_value", commit_value, 32'd0);
    chk("rst_mid_commit_tag", 32'(commit_tag), 32'd0);
    chk("rst_mid_flush", 32'(flush), 32'd0);
    chk("rst_mid_flush_pc", flush_pc, 32'd0);
    chk("rst_mid_full", 32'(rob_full), 32'd0);
    chk("rst_mid_alloc_tag", 32'(alloc_tag), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst              = ($urandom_range(0, 299) == 0);
      rdy              = ($urandom_range(0, 9) != 0);
      alloc_valid      = $urandom_range(0, 1);
      alloc_has_rd     = $urandom_range(0, 3) != 0;
      alloc_is_branch  = ($urandom_range(0, 4) == 0);
      alloc_pred_taken = $urandom_range(0, 1);
      alloc_rd         = 5'($urandom);
      wb_valid         = ($urandom_range(0, 9) < 4);
      wb_value         = $urandom;
      wb_target        = $urandom;
      wb_taken         = $urandom_range(0, 1);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
        pick   = $urandom_range(0, mq.size() - 1);
        wb_tag = TAG_W'(mq[pick].tag);
        if (mq[pick].is_branch)
          wb_taken = ($urandom_range(0, 5) == 0) ? !mq[pick].pred : mq[pick].pred;
      end else begin
        wb_tag = TAG_W'($urandom);
      end
      cand.delete();
      foreach (mq[k]) if (!mq[k].is_branch) cand.push_back(mq[k].tag);
      simple_done = 0;
      if (cand.size() > 0 && $urandom_range(0, 4) == 0) begin
        simple_done = 1;
        simple_tag  = TAG_W'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      step();
    end

    idle();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
